// File: rtl/range_finder_param_if.sv
// -----------------------------------------------------------------------------
// range_finder_param_if
// Bundles the sample bus of range_finder_param.
//   master : drives data_in/go/finish, observes the session results
//   slave  : the range finder itself
// Signals:
//   data_in      WIDTH   sample value
//   go           1       start of session (data_in is the first sample)
//   finish       1       end of session   (data_in is the last sample)
//   range        WIDTH+1 max - min of the last completed session, unsigned
//   min_out      WIDTH   smallest sample of the last completed session
//   max_out      WIDTH   largest sample of the last completed session
//   sample_count CNT_W   saturating sample count of the last completed session
//   count_sat    1       sample_count saturated during that session
//   valid        1       result outputs hold a completed session
//   debug_error  1       protocol violation seen, sticky until reset
// -----------------------------------------------------------------------------
interface range_finder_param_if #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] data_in;
  logic             go;
  logic             finish;
  logic [WIDTH:0]   range;
  logic [WIDTH-1:0] min_out;
  logic [WIDTH-1:0] max_out;
  logic [CNT_W-1:0] sample_count;
  logic             count_sat;
  logic             valid;
  logic             debug_error;

  modport master (
    output data_in, go, finish,
    input  range, min_out, max_out, sample_count, count_sat, valid, debug_error
  );

  modport slave (
    input  data_in, go, finish,
    output range, min_out, max_out, sample_count, count_sat, valid, debug_error
  );
endinterface

// File: rtl/range_finder_param.sv
// -----------------------------------------------------------------------------
// range_finder_param
// Tracks min, max, range and sample count over a go..finish session of
// samples and publishes the results one cycle after the finish cycle.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   bus    range_finder_param_if.slave (sample inputs, result outputs)
// Parameters:
//   WIDTH  sample width (>= 2)
//   CNT_W  sample counter width (>= 2)
//   SIGNED 0: unsigned compare, 1: two's complement compare
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module range_finder_param #(
  parameter int WIDTH  = 10,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 0
) (
  input logic                 clock,
  input logic                 reset,
  range_finder_param_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERROR} state_t;

  state_t state, state_nxt;

  // Decoded per-cycle actions of the FSM.
  logic start;   // first sample of a new session
  logic accept;  // further sample inside RUN (includes the final one)
  logic last;    // final sample: publish results

  // Working registers of the session in progress.
  logic [WIDTH-1:0] work_min, work_max;
  logic [CNT_W-1:0] work_cnt;
  logic             work_sat;

  // Published results.
  logic [WIDTH:0]   res_range;
  logic [WIDTH-1:0] res_min, res_max;
  logic [CNT_W-1:0] res_cnt;
  logic             res_sat;

  // Working values with the current sample folded in.
  logic [WIDTH-1:0] min_upd, max_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             sat_upd;
  logic [WIDTH:0]   range_upd;

  // Widen by one bit so a single signed compare/subtract covers both
  // encodings: sign-extend when SIGNED, zero-extend otherwise.
  function automatic logic signed [WIDTH:0] ext(input logic [WIDTH-1:0] v);
    return $signed({(SIGNED != 0) ? v[WIDTH-1] : 1'b0, v});
  endfunction

  // NOTE: the clocked block holds state only and uses non-blocking
  // assignments, so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.finish) begin
          state_nxt = ERROR;
        end else if (bus.go) begin
          state_nxt = RUN;
          start     = 1'b1;
        end
      end
      RUN: begin
        // A go inside a session is a violation; its sample is dropped.
        if (bus.go) begin
          state_nxt = ERROR;
        end else begin
          accept = 1'b1;
          if (bus.finish) begin
            last      = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      ERROR: state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    min_upd   = (ext(bus.data_in) < ext(work_min)) ? bus.data_in : work_min;
    max_upd   = (ext(bus.data_in) > ext(work_max)) ? bus.data_in : work_max;
    // Counter sticks at all-ones; the first increment attempted there
    // raises the saturation flag.
    sat_upd   = work_sat | (&work_cnt);
    cnt_upd   = (&work_cnt) ? work_cnt : work_cnt + CNT_W'(1);
    // max >= min, so the WIDTH+1-bit difference is exact as unsigned.
    range_upd = ext(max_upd) - ext(min_upd);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      work_min <= '0;
      work_max <= '0;
      work_cnt <= '0;
      work_sat <= 1'b0;
    end else if (start) begin
      work_min <= bus.data_in;
      work_max <= bus.data_in;
      work_cnt <= CNT_W'(1);
      work_sat <= 1'b0;
    end else if (accept) begin
      work_min <= min_upd;
      work_max <= max_upd;
      work_cnt <= cnt_upd;
      work_sat <= sat_upd;
    end
  end

  // Results move only when a session completes or on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      res_range <= '0;
      res_min   <= '0;
      res_max   <= '0;
      res_cnt   <= '0;
      res_sat   <= 1'b0;
    end else if (last) begin
      res_range <= range_upd;
      res_min   <= min_upd;
      res_max   <= max_upd;
      res_cnt   <= cnt_upd;
      res_sat   <= sat_upd;
    end
  end

  assign bus.range        = res_range;
  assign bus.min_out      = res_min;
  assign bus.max_out      = res_max;
  assign bus.sample_count = res_cnt;
  assign bus.count_sat    = res_sat;
  assign bus.valid        = (state == DONE);
  assign bus.debug_error  = (state == ERROR);

endmodule

// File: tb/tb_range_finder_param.sv
// -----------------------------------------------------------------------------
// tb_range_finder_param
// Three range finders share one stimulus stream:
//   dut0 : WIDTH=10 CNT_W=8 unsigned
//   dut1 : WIDTH=10 CNT_W=8 signed
//   dut2 : WIDTH=10 CNT_W=3 unsigned
// A session-level reference model (queue of the samples of the current
// session, min/max/count computed with plain integer arithmetic on finish)
// predicts every output of every instance on every cycle.
// -----------------------------------------------------------------------------
module tb_range_finder_param;
  localparam int W = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         go_s  = 1'b0;
  logic         fin_s = 1'b0;
  logic [W-1:0] din_s = '0;

  always #5 clock = ~clock;

  range_finder_param_if #(.WIDTH(W), .CNT_W(8)) bus0 ();
  range_finder_param_if #(.WIDTH(W), .CNT_W(8)) bus1 ();
  range_finder_param_if #(.WIDTH(W), .CNT_W(3)) bus2 ();

  assign bus0.data_in = din_s;  assign bus0.go = go_s;  assign bus0.finish = fin_s;
  assign bus1.data_in = din_s;  assign bus1.go = go_s;  assign bus1.finish = fin_s;
  assign bus2.data_in = din_s;  assign bus2.go = go_s;  assign bus2.finish = fin_s;

  range_finder_param #(.WIDTH(W), .CNT_W(8), .SIGNED(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  range_finder_param #(.WIDTH(W), .CNT_W(8), .SIGNED(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
  range_finder_param #(.WIDTH(W), .CNT_W(3), .SIGNED(0)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_DONE, M_ERR} mstate_t;
  mstate_t      m = M_IDLE;
  logic [W-1:0] sess[$];
  int           e_rng[3], e_min[3], e_max[3], e_cnt[3];
  bit           e_sat[3];

  function automatic int to_val(input logic [W-1:0] v, input bit s);
    return (s && v[W-1]) ? int'(v) - (1 << W) : int'(v);
  endfunction

  function automatic int cnt_max(input int i);
    return (i == 2) ? 7 : 255;
  endfunction

  task automatic clear_results();
    for (int i = 0; i < 3; i++) begin
      e_rng[i] = 0; e_min[i] = 0; e_max[i] = 0; e_cnt[i] = 0; e_sat[i] = 0;
    end
  endtask

  task automatic publish();
    for (int i = 0; i < 3; i++) begin
      int lo = 1 << 20;
      int hi = -(1 << 20);
      foreach (sess[k]) begin
        int v = to_val(sess[k], i == 1);
        if (v < lo) lo = v;
        if (v > hi) hi = v;
      end
      e_min[i] = lo & ((1 << W) - 1);
      e_max[i] = hi & ((1 << W) - 1);
      e_rng[i] = hi - lo;
      e_cnt[i] = (sess.size() > cnt_max(i)) ? cnt_max(i) : sess.size();
      e_sat[i] = sess.size() > cnt_max(i);
    end
  endtask

  task automatic model_step(input bit r, input bit g, input bit f, input logic [W-1:0] d);
    if (r) begin
      m = M_IDLE;
      sess.delete();
      clear_results();
    end else begin
      case (m)
        M_IDLE, M_DONE: begin
          if (f) m = M_ERR;
          else if (g) begin
            m = M_RUN;
            sess.delete();
            sess.push_back(d);
          end
        end
        M_RUN: begin
          if (g) m = M_ERR;
          else begin
            sess.push_back(d);
            if (f) begin
              publish();
              m = M_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_dut(input int i, input logic [31:0] rng, input logic [31:0] mn,
                           input logic [31:0] mx, input logic [31:0] cnt,
                           input logic sat, input logic vld, input logic err);
    check($sformatf("dut%0d.range", i),        rng, 32'(e_rng[i]));
    check($sformatf("dut%0d.min_out", i),      mn,  32'(e_min[i]));
    check($sformatf("dut%0d.max_out", i),      mx,  32'(e_max[i]));
    check($sformatf("dut%0d.sample_count", i), cnt, 32'(e_cnt[i]));
    check($sformatf("dut%0d.count_sat", i),    32'(sat), 32'(e_sat[i]));
    check($sformatf("dut%0d.valid", i),        32'(vld), 32'(m == M_DONE));
    check($sformatf("dut%0d.debug_error", i),  32'(err), 32'(m == M_ERR));
  endtask

  task automatic check_all();
    check_dut(0, 32'(bus0.range), 32'(bus0.min_out), 32'(bus0.max_out),
              32'(bus0.sample_count), bus0.count_sat, bus0.valid, bus0.debug_error);
    check_dut(1, 32'(bus1.range), 32'(bus1.min_out), 32'(bus1.max_out),
              32'(bus1.sample_count), bus1.count_sat, bus1.valid, bus1.debug_error);
    check_dut(2, 32'(bus2.range), 32'(bus2.min_out), 32'(bus2.max_out),
              32'(bus2.sample_count), bus2.count_sat, bus2.valid, bus2.debug_error);
  endtask

  // One clock: drive on the falling edge, advance the model at the rising
  // edge, compare 1 time unit later.
  task automatic step(input bit r, input bit g, input bit f, input logic [W-1:0] d);
    @(negedge clock);
    reset = r; go_s = g; fin_s = f; din_s = d;
    @(posedge clock);
    model_step(r, g, f, d);
    #1;
    check_all();
  endtask

  function automatic logic [W-1:0] rand_sample();
    logic [W-1:0] edge_vals[4];
    edge_vals[0] = '0;
    edge_vals[1] = '1;
    edge_vals[2] = 10'h200;
    edge_vals[3] = 10'h1FF;
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 3)];
    return W'($urandom_range(0, (1 << W) - 1));
  endfunction

  initial begin
    // Reset state, and reset winning over go on the same cycle.
    step(1, 0, 0, '0);
    step(1, 1, 0, 10'd5);
    step(0, 0, 0, '0);

    // Basic session 5, 12, 3, finish 7.
    step(0, 1, 0, 10'd5);
    step(0, 0, 0, 10'd12);
    step(0, 0, 0, 10'd3);
    step(0, 0, 1, 10'd7);
    check("basic.range", 32'(bus0.range), 32'd9);
    check("basic.min", 32'(bus0.min_out), 32'd3);
    check("basic.max", 32'(bus0.max_out), 32'd12);
    check("basic.count", 32'(bus0.sample_count), 32'd4);
    check("basic.valid", 32'(bus0.valid), 32'd1);
    check("basic.err", 32'(bus0.debug_error), 32'd0);

    // go inside a session after 3 samples: error, previous results kept.
    step(0, 1, 0, 10'd100);
    step(0, 0, 0, 10'd200);
    step(0, 0, 0, 10'd300);
    step(0, 1, 0, 10'd0);
    check("midgo.err", 32'(bus0.debug_error), 32'd1);
    check("midgo.min_kept", 32'(bus0.min_out), 32'd3);
    check("midgo.max_kept", 32'(bus0.max_out), 32'd12);

    // go and finish together from IDLE, then 10 idle cycles.
    step(1, 0, 0, '0);
    step(0, 1, 1, 10'd1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, '0);
    check("gofin.err_held", 32'(bus0.debug_error), 32'd1);
    check("gofin.valid_low", 32'(bus0.valid), 32'd0);
    step(1, 0, 0, '0);
    check("gofin.err_cleared", 32'(bus0.debug_error), 32'd0);

    // Signed extremes.
    step(0, 1, 0, 10'h200);
    step(0, 0, 1, 10'h1FF);
    check("signed.range", 32'(bus1.range), 32'd1023);
    check("signed.min", 32'(bus1.min_out), 32'h200);
    check("signed.max", 32'(bus1.max_out), 32'h1FF);

    // Counter saturation on the CNT_W=3 instance, then a short session.
    step(0, 1, 0, rand_sample());
    for (int i = 0; i < 8; i++) step(0, 0, 0, rand_sample());
    step(0, 0, 1, rand_sample());
    check("sat.count", 32'(bus2.sample_count), 32'd7);
    check("sat.flag", 32'(bus2.count_sat), 32'd1);
    step(0, 1, 0, 10'd4);
    step(0, 0, 1, 10'd9);
    check("sat.short_count", 32'(bus2.sample_count), 32'd2);
    check("sat.short_flag", 32'(bus2.count_sat), 32'd0);

    // Reset mid-session, then a finish while IDLE.
    step(0, 1, 0, 10'd50);
    step(0, 0, 0, 10'd60);
    step(1, 0, 0, 10'd70);
    check("rstmid.range", 32'(bus0.range), 32'd0);
    check("rstmid.count", 32'(bus0.sample_count), 32'd0);
    step(0, 0, 1, 10'd80);
    check("rstmid.fin_err", 32'(bus0.debug_error), 32'd1);
    step(1, 0, 0, '0);

    // Randomized sessions with occasional protocol violations and resets.
    for (int s = 0; s < 300; s++) begin
      int r = $urandom_range(0, 99);
      int gap = $urandom_range(0, 3);
      for (int i = 0; i < gap; i++) step(0, 0, 0, rand_sample());
      if (r < 5) begin
        step(0, 1, 1, rand_sample());
        step(0, 0, 0, rand_sample());
        step(1, 0, 0, '0);
      end else if (r < 10) begin
        step(0, $urandom_range(0, 1) == 1, 1, rand_sample());
        step(0, 1, 0, rand_sample());
        step(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rand_sample());
      end else begin
        int len = (r < 15) ? $urandom_range(250, 300) : $urandom_range(0, 12);
        int tail = $urandom_range(0, 19);
        step(0, 1, 0, rand_sample());
        for (int i = 0; i < len; i++) step(0, 0, 0, rand_sample());
        if (tail < 2) begin
          step(0, 1, $urandom_range(0, 1) == 1, rand_sample());
          step(0, 0, 0, rand_sample());
          step(1, 0, 0, '0);
        end else if (tail < 4) begin
          step(1, 0, $urandom_range(0, 1) == 1, rand_sample());
        end else begin
          step(0, 0, 1, rand_sample());
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
